blockmix_salsa_ctrl: RTL

- Initiator side of the Salsa20/8 core handshake. Implements scrypt BlockMix_salsa20/8 over 2*R 512-bit blocks.
- Drives the core's enable/data inputs and consumes its hash_done/result outputs; the core sits outside this block.
- Sits between the scrypt ROMix sequencer (above) and the Salsa20/8 core (below).

---
 rtl/blockmix_salsa_ctrl_pkg.sv | 19 +
 rtl/blockmix_salsa_ctrl_if.sv | 24 ++
 rtl/blockmix_salsa_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/blockmix_salsa_ctrl_pkg.sv
// rtl/blockmix_salsa_ctrl_pkg.sv - shared scrypt types, widths and BlockMix output-slot mapping
package scrypt_pkg;

  localparam int SALSA_BLOCK_W = 512;
  localparam int WORD_W        = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } blockmix_state_t;

  // Even outputs fill the first half of B', odd outputs the second half.
  function automatic int y_slot(input int i, input int r);
    return (i % 2 == 0) ? (i / 2) : (r + (i - 1) / 2);
  endfunction

endpackage

// File: rtl/blockmix_salsa_ctrl_if.sv
// rtl/blockmix_salsa_ctrl_if.sv - Salsa20/8 core request/completion handshake
interface blockmix_salsa_ctrl_if;
  import scrypt_pkg::*;

  logic                     sal_enable;
  logic [SALSA_BLOCK_W-1:0] sal_data;
  logic                     sal_done;
  logic [SALSA_BLOCK_W-1:0] sal_result;

  modport master (
    output sal_enable,
    output sal_data,
    input  sal_done,
    input  sal_result
  );

  modport slave (
    input  sal_enable,
    input  sal_data,
    output sal_done,
    output sal_result
  );

endinterface

// File: rtl/blockmix_salsa_ctrl.sv
// rtl/blockmix_salsa_ctrl.sv - scrypt BlockMix_salsa20/8 sequencer driving an external Salsa20/8 core
// Optional core watchdog: define BLOCKMIX_WATCHDOG_EN.
module blockmix_salsa_ctrl
  import scrypt_pkg::*;
#(
  parameter int R           = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [1024*R-1:0]      in_data,
  output logic                   busy,
  output logic                   done,
  output logic [1024*R-1:0]      out_data,
  blockmix_salsa_ctrl_if.master  sal,
  output logic                   err
);

  localparam int NBLK   = 2 * R;
  localparam int BW     = SALSA_BLOCK_W;
  localparam int NWORDS = SALSA_BLOCK_W / WORD_W;
  localparam int IDX_W  = (NBLK > 2) ? $clog2(NBLK) : 1;

  blockmix_state_t  state;
  blockmix_state_t  state_next;
  logic [IDX_W-1:0] index;
  logic [BW-1:0]    x_reg;
  logic [NBLK*BW-1:0] b_reg;
  logic [BW-1:0]    b_sel;
  logic             last_blk;
  logic             timeout;

  assign last_blk = (index == IDX_W'(NBLK - 1));

  always_comb begin
    b_sel = b_reg[BW*(NBLK-1-int'(index)) +: BW];
  end

`ifdef BLOCKMIX_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt <= '0;
    end else if (state == LOAD) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires in the WAIT cycle that completes TIMEOUT_CYC cycles since LOAD.
  assign timeout = (state == WAIT) && !sal.sal_done && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = WAIT;
      WAIT: begin
        if (sal.sal_done) begin
          state_next = last_blk ? DONE : LOAD;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    done           = (state == DONE);
    sal.sal_enable = (state == LOAD);
    err            = timeout;
    sal.sal_data   = '0;
    for (int w = 0; w < NWORDS; w++) begin
      sal.sal_data[w*WORD_W +: WORD_W] = x_reg[w*WORD_W +: WORD_W] ^ b_sel[w*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      b_reg    <= '0;
      x_reg    <= '0;
      index    <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            b_reg <= in_data;
            x_reg <= in_data[BW-1:0];
            index <= '0;
          end
        end
        WAIT: begin
          if (sal.sal_done) begin
            x_reg <= sal.sal_result;
            out_data[BW*(NBLK-1-y_slot(int'(index), R)) +: BW] <= sal.sal_result;
            if (!last_blk) begin
              index <= index + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
